// File: rtl/branch_cond_unit.sv
// rtl/branch_cond_unit.sv - conditional branch evaluator between flags register, control unit and PC
module branch_cond_unit #(
   parameter int ADDR_W  = 16,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              br_valid,
   output logic              br_ready,
   input  logic [3:0]        br_cond,
   input  logic [ADDR_W-1:0] br_target,
   input  logic              alu_busy,
   input  logic              ALU_ready,
   input  logic [3:0]        flags,
   output logic              pc_load,
   output logic [ADDR_W-1:0] pc_target,
   output logic              br_taken,
   output logic              br_done,
   output logic              br_err
);

   typedef enum logic [1:0] {S_IDLE, S_WAIT, S_EVAL, S_RESP} state_t;

   localparam logic [7:0] TIMEOUT_LAST = 8'(TIMEOUT - 1);

   state_t            state, state_nxt;
   logic [7:0]        wait_cnt, wait_cnt_nxt;
   logic [3:0]        cond_q;
   logic [ADDR_W-1:0] target_q;
   logic              taken_q;
   logic              accept;
   logic              timeout_hit;
   logic              pc_load_nxt, br_taken_nxt, br_done_nxt, br_err_nxt;

   // flags layout: [0]=Z, [1]=N, [2]=C, [3]=V
   function automatic logic eval_cond(input logic [3:0] cc, input logic [3:0] f);
      logic z, n, c, v;
      z = f[0];
      n = f[1];
      c = f[2];
      v = f[3];
      case (cc)
         4'd0:    eval_cond = 1'b1;
         4'd1:    eval_cond = z;
         4'd2:    eval_cond = !z;
         4'd3:    eval_cond = c;
         4'd4:    eval_cond = !c;
         4'd5:    eval_cond = n;
         4'd6:    eval_cond = !n;
         4'd7:    eval_cond = v;
         4'd8:    eval_cond = !v;
         4'd9:    eval_cond = !z && (n == v);
         4'd10:   eval_cond = (n == v);
         4'd11:   eval_cond = (n != v);
         4'd12:   eval_cond = z || (n != v);
         4'd13:   eval_cond = c && !z;
         4'd14:   eval_cond = !c || z;
         default: eval_cond = 1'b0;
      endcase
   endfunction

   assign br_ready    = (state == S_IDLE);
   assign accept      = br_valid && br_ready;
   assign timeout_hit = (wait_cnt == TIMEOUT_LAST);

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state    <= S_IDLE;
         wait_cnt <= 8'd0;
      end else begin
         state    <= state_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   // ALU_ready beats both alu_busy at accept and the timeout in WAIT
   always_comb begin
      state_nxt    = state;
      wait_cnt_nxt = wait_cnt;
      case (state)
         S_IDLE: begin
            wait_cnt_nxt = 8'd0;
            if (accept)
               state_nxt = (alu_busy && !ALU_ready) ? S_WAIT : S_EVAL;
         end
         S_WAIT: begin
            if (ALU_ready) begin
               state_nxt    = S_EVAL;
               wait_cnt_nxt = 8'd0;
            end else if (timeout_hit) begin
               state_nxt    = S_IDLE;
               wait_cnt_nxt = 8'd0;
            end else begin
               wait_cnt_nxt = wait_cnt + 8'd1;
            end
         end
         S_EVAL:  state_nxt = S_RESP;
         S_RESP:  state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   always_comb begin
      pc_load_nxt  = 1'b0;
      br_taken_nxt = 1'b0;
      br_done_nxt  = 1'b0;
      br_err_nxt   = 1'b0;
      if (state == S_RESP) begin
         br_done_nxt  = 1'b1;
         br_taken_nxt = taken_q;
         pc_load_nxt  = taken_q;
      end
      if (state == S_WAIT && !ALU_ready && timeout_hit)
         br_err_nxt = 1'b1;
   end

   // pc_target only moves when a taken branch loads the PC
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         cond_q    <= 4'd0;
         target_q  <= '0;
         taken_q   <= 1'b0;
         pc_load   <= 1'b0;
         pc_target <= '0;
         br_taken  <= 1'b0;
         br_done   <= 1'b0;
         br_err    <= 1'b0;
      end else begin
         pc_load  <= pc_load_nxt;
         br_taken <= br_taken_nxt;
         br_done  <= br_done_nxt;
         br_err   <= br_err_nxt;
         if (accept) begin
            cond_q   <= br_cond;
            target_q <= br_target;
         end
         if (state == S_EVAL)
            taken_q <= eval_cond(cond_q, flags);
         if (pc_load_nxt)
            pc_target <= target_q;
      end
   end

endmodule

// File: tb/tb_branch_cond_unit.sv
// tb/tb_branch_cond_unit.sv - self-checking bench for branch_cond_unit
module tb_branch_cond_unit;

   localparam int ADDR_W  = 16;
   localparam int TIMEOUT = 15;

   logic              clk = 1'b0;
   logic              reset = 1'b0;
   logic              br_valid = 1'b0;
   logic              br_ready;
   logic [3:0]        br_cond = 4'd0;
   logic [ADDR_W-1:0] br_target = '0;
   logic              alu_busy = 1'b0;
   logic              ALU_ready = 1'b0;
   logic [3:0]        flags = 4'd0;
   logic              pc_load;
   logic [ADDR_W-1:0] pc_target;
   logic              br_taken;
   logic              br_done;
   logic              br_err;

   branch_cond_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
      .clk       (clk),
      .reset     (reset),
      .br_valid  (br_valid),
      .br_ready  (br_ready),
      .br_cond   (br_cond),
      .br_target (br_target),
      .alu_busy  (alu_busy),
      .ALU_ready (ALU_ready),
      .flags     (flags),
      .pc_load   (pc_load),
      .pc_target (pc_target),
      .br_taken  (br_taken),
      .br_done   (br_done),
      .br_err    (br_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   typedef struct {
      int                cyc;
      bit                err;
      bit                taken;
      logic [ADDR_W-1:0] tgt;
   } ev_t;

   ev_t               evq[$];
   logic [ADDR_W-1:0] exp_pc = '0;
   int                n_checks = 0;
   int                n_fail = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Conditions viewed as compare results: slt = signed less-than, ult = unsigned borrow
   function automatic bit model_taken(input logic [3:0] c, input logic [3:0] f);
      bit z, n, v, ult, slt;
      bit [15:0] tbl;
      z   = f[0];
      n   = f[1];
      ult = !f[2];
      v   = f[3];
      slt = n ^ v;
      tbl = {1'b0, ult | z, !ult & !z, z | slt, slt, !slt, !z & !slt,
             !v, v, !n, n, ult, !ult, !z, z, 1'b1};
      return tbl[c];
   endfunction

   always @(negedge clk) begin
      if (!reset) begin
         exp_pc = '0;
         chk("reset_pulses", 32'({pc_load, br_done, br_err, br_taken}), 0);
         chk("reset_pc_target", 32'(pc_target), 0);
      end else if (evq.size() > 0 && evq[0].cyc == cyc) begin
         chk("resp_br_ready", 32'(br_ready), 1);
         if (evq[0].err) begin
            chk("timeout_br_err", 32'(br_err), 1);
            chk("timeout_no_done", 32'({br_done, pc_load}), 0);
         end else begin
            chk("resp_br_done", 32'(br_done), 1);
            chk("resp_br_taken", 32'(br_taken), 32'(evq[0].taken));
            chk("resp_pc_load", 32'(pc_load), 32'(evq[0].taken));
            chk("resp_no_err", 32'(br_err), 0);
            if (evq[0].taken) exp_pc = evq[0].tgt;
            chk("resp_pc_target", 32'(pc_target), 32'(exp_pc));
         end
         void'(evq.pop_front());
      end else begin
         chk("idle_no_pulse", 32'({br_done, pc_load, br_err}), 0);
         chk("pc_target_hold", 32'(pc_target), 32'(exp_pc));
      end
   end

   // d: cycles from accept until ALU_ready is sampled; negative means never
   task automatic do_req(input logic [3:0] c, input logic [ADDR_W-1:0] t, input logic [3:0] f_pre,
                         input logic [3:0] f, input bit busy, input bit rdy0, input int d);
      ev_t e;
      int  t0;
      bit  waits;
      waits = busy && !rdy0;
      @(negedge clk);
      for (int i = 0; i < 50 && !br_ready; i++) @(negedge clk);
      chk("accept_ready", 32'(br_ready), 1);
      br_valid  = 1'b1;
      br_cond   = c;
      br_target = t;
      alu_busy  = busy;
      ALU_ready = rdy0;
      flags     = waits ? f_pre : f;
      @(posedge clk);
      #1;
      t0 = cyc;
      br_valid  = 1'b0;
      ALU_ready = 1'b0;
      chk("ready_low_after_accept", 32'(br_ready), 0);
      e.tgt   = t;
      e.taken = model_taken(c, f);
      e.err   = 1'b0;
      if (!waits) begin
         e.cyc = t0 + 2;
      end else if (d < 0) begin
         e.cyc   = t0 + TIMEOUT;
         e.err   = 1'b1;
         e.taken = 1'b0;
      end else begin
         e.cyc = t0 + d + 2;
      end
      evq.push_back(e);
      if (waits && d > 0) begin
         repeat (d - 1) @(posedge clk);
         #1;
         ALU_ready = 1'b1;
         flags     = f;
         @(posedge clk);
         #1;
         ALU_ready = 1'b0;
      end
      for (int i = 0; i < 40 && evq.size() > 0; i++) begin
         @(negedge clk);
         #1;
      end
      if (evq.size() > 0) begin
         chk("response_bound", 32'(evq.size()), 0);
         evq.delete();
      end
      alu_busy = 1'b0;
   endtask

   task automatic reset_mid(input bit in_eval);
      @(negedge clk);
      br_valid  = 1'b1;
      br_cond   = 4'd0;
      br_target = 16'hBEEF;
      alu_busy  = !in_eval;
      ALU_ready = 1'b0;
      flags     = 4'd0;
      @(posedge clk);
      #1;
      br_valid = 1'b0;
      if (!in_eval) begin
         repeat (3) @(posedge clk);
         #1;
      end
      #1 reset = 1'b0;
      #1;
      chk("async_reset_pulses", 32'({pc_load, br_done, br_err, br_taken}), 0);
      chk("async_reset_pc_target", 32'(pc_target), 0);
      repeat (2) @(negedge clk);
      #2 reset = 1'b1;
      alu_busy = 1'b0;
      repeat (20) @(negedge clk);
      #1;
      chk("ready_after_reset", 32'(br_ready), 1);
      do_req(4'd1, 16'h4321, 4'b0000, 4'b0001, 1'b0, 1'b0, 0);
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      reset = 1'b0;
      repeat (3) @(negedge clk);
      #2 reset = 1'b1;
      @(negedge clk);
      #1;
      chk("ready_out_of_reset", 32'(br_ready), 1);

      chk("model_eq_z", 32'(model_taken(4'd1, 4'b0001)), 1);
      chk("model_gt_nv", 32'(model_taken(4'd9, 4'b1010)), 1);
      chk("model_le_n", 32'(model_taken(4'd12, 4'b0010)), 1);
      chk("model_hi_c", 32'(model_taken(4'd13, 4'b0100)), 1);
      chk("model_ls_cz", 32'(model_taken(4'd14, 4'b0101)), 1);
      chk("model_lt_nv", 32'(model_taken(4'd11, 4'b1010)), 0);

      do_req(4'd1,  16'h1234, 4'b0000, 4'b0001, 1'b0, 1'b0, 0);
      do_req(4'd2,  16'h5678, 4'b0000, 4'b0001, 1'b0, 1'b0, 0);
      do_req(4'd9,  16'hABCD, 4'b0001, 4'b1010, 1'b1, 1'b0, 3);
      do_req(4'd13, 16'h0F0F, 4'b0000, 4'b0100, 1'b1, 1'b1, 0);
      do_req(4'd0,  16'hDEAD, 4'b0000, 4'b0000, 1'b1, 1'b0, -1);
      do_req(4'd12, 16'h1111, 4'b0000, 4'b0010, 1'b1, 1'b0, 15);
      do_req(4'd7,  16'h2222, 4'b0000, 4'b1000, 1'b1, 1'b0, 14);
      do_req(4'd15, 16'h3333, 4'b0000, 4'b1111, 1'b1, 1'b0, 1);

      for (int c = 0; c < 16; c++)
         for (int f = 0; f < 16; f++)
            do_req(4'(c), 16'(c * 256 + f * 16 + 1), 4'(f), 4'(f), 1'b0, 1'b0, 0);

      reset_mid(1'b0);
      reset_mid(1'b1);

      repeat (3) @(negedge clk);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_cond_unit.md
Name: branch_cond_unit

Overview:
- Consumer side of the 4-bit flags register. Accepts a conditional-branch request from the control unit and, if the ALU is still busy, waits for ALU_ready so the flags are final.
- Evaluates the condition code against the flags, then drives a one-cycle PC-load strobe with the branch target when the branch is taken.
- Sits between the flags register, the control unit and the program counter.

Parameters:
- ADDR_W, 16, width of branch target / PC.
- TIMEOUT, 15, max cycles spent in WAIT before aborting with br_err. Range 1..255.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- br_valid  in  1  control unit presents a branch request.
- br_ready  out  1  unit can accept a request (high only in IDLE).
- br_cond  in  4  condition code, sampled on accept.
- br_target  in  ADDR_W  branch destination, sampled on accept.
- alu_busy  in  1  ALU op in flight; flags not yet final.
- ALU_ready  in  1  ALU result/flags valid this cycle.
- flags  in  4  flags register output: [0]=Z, [1]=N, [2]=C, [3]=V.
- pc_load  out  1  one-cycle strobe; PC <= pc_target.
- pc_target  out  ADDR_W  registered target, valid while pc_load=1.
- br_taken  out  1  evaluation result, valid while br_done=1.
- br_done  out  1  one-cycle completion pulse.
- br_err  out  1  one-cycle timeout pulse; no PC load on that request.

Behaviour:
- Reset (reset=0, async): state=IDLE, wait counter=0. pc_load, br_taken, br_done and br_err are 0; pc_target is 0. br_ready=1 once reset is released.
- Every output except br_ready is registered. br_ready is decoded from state (IDLE).
- States: IDLE, WAIT, EVAL, RESP.
- IDLE: on br_valid&br_ready, capture br_cond and br_target.
  - If alu_busy=1 and ALU_ready=0, go to WAIT.
  - Otherwise go to EVAL. ALU_ready in the accept cycle wins over alu_busy.
- WAIT: the counter increments every cycle.
  - ALU_ready=1 -> EVAL; counter cleared.
  - Otherwise, when counter==TIMEOUT-1 -> IDLE, with br_err=1 in the next cycle and the counter cleared.
  - If ALU_ready and the timeout coincide, ALU_ready wins.
- EVAL: sample flags and compute taken. Next state is RESP.
- Condition codes (br_cond -> taken):
  - 0 AL: 1
  - 1 EQ: Z
  - 2 NE: !Z
  - 3 CS: C
  - 4 CC: !C
  - 5 MI: N
  - 6 PL: !N
  - 7 VS: V
  - 8 VC: !V
  - 9 GT: !Z&(N==V)
  - 10 GE: N==V
  - 11 LT: N!=V
  - 12 LE: Z|(N!=V)
  - 13 HI: C&!Z
  - 14 LS: !C|Z
  - 15 NV: 0
- RESP (1 cycle): br_done=1, br_taken=taken, pc_load=taken, pc_target=captured target. Next state is IDLE.
- Latency: accept at edge T; RESP outputs are visible after edge T+2 with no wait, or 2 cycles after the ALU_ready cycle when waiting.
- br_valid outside IDLE is ignored; the requester must hold the request until br_ready.
- Back-to-back requests: the earliest next accept is the cycle RESP outputs are visible (IDLE again).
- pc_load, br_done and br_err are strictly single-cycle and mutually exclusive with br_err.
- Reset asserted mid-operation aborts immediately; no pc_load or br_done is ever emitted for the aborted request.

Test Plan:
1. Accept EQ (1), target=0x1234, alu_busy=0, flags=0001 -> 2 cycles later br_done=1, br_taken=1, pc_load=1, pc_target=0x1234 for exactly one cycle.
2. Accept NE (2), flags=0001, alu_busy=0 -> br_done=1, br_taken=0, pc_load=0, pc_target not loaded.
3. Accept GT (9), alu_busy=1. Pulse ALU_ready 3 cycles later with flags=1010 (N=1, V=1, Z=0) -> taken=1, br_done 2 cycles after ALU_ready.
4. Accept with alu_busy=1 and no ALU_ready, TIMEOUT=15 -> br_err=1 exactly once, 15 cycles after accept. No br_done or pc_load; br_ready=1 afterwards.
5. Sweep all 16 codes against all 16 flag values (256 requests) -> br_taken matches the condition table; AL is always 1, NV always 0.
6. Pull reset low while in WAIT, and separately in EVAL -> all outputs 0 asynchronously and no pulse follows. After release, br_ready=1 and a new request completes normally.
